sprite_mem_loader: RTL and testbench

//  Write-side counterpart of the sprite ROM readers: accepts a byte stream (from UART/host bridge) and loads
//  a sprite's palette RAM (12-bit RGB) and image RAM (8-bit palette indices, row-major, addr = x + y*WIDTH).

---
 rtl/sprite_mem_loader.sv | 158 +++++++++++++++
 tb/tb_sprite_mem_loader.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_mem_loader.sv
// Sprite RAM loader: turns a command/payload byte stream into
// palette and image RAM write strobes for one sprite.
module sprite_mem_loader #(
  parameter int WIDTH         = 100,
  parameter int HEIGHT        = 100,
  parameter int PALETTE_DEPTH = 100,
  localparam int NPIX = WIDTH * HEIGHT,
  localparam int IAW  = (NPIX > 1) ? $clog2(NPIX) : 1,
  localparam int PAW  = (PALETTE_DEPTH > 1) ? $clog2(PALETTE_DEPTH) : 1
) (
  input  logic           pixel_clk_in,
  input  logic           rst_in,
  input  logic [7:0]     data_in,
  input  logic           valid_in,
  output logic           ready_out,
  input  logic           abort_in,
  output logic [IAW-1:0] img_addr_out,
  output logic [7:0]     img_data_out,
  output logic           img_we_out,
  output logic [PAW-1:0] pal_addr_out,
  output logic [11:0]    pal_data_out,
  output logic           pal_we_out,
  output logic           busy_out,
  output logic           done_out,
  output logic           err_out
);

  localparam logic [7:0] CMD_PAL = 8'hA5;
  localparam logic [7:0] CMD_IMG = 8'h5A;
  localparam logic [IAW-1:0] LAST_PIX = IAW'(NPIX - 1);
  localparam logic [PAW-1:0] LAST_ENT = PAW'(PALETTE_DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    PAL_HI,
    PAL_LO,
    IMG,
    DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic           accept;
  logic           in_range;
  logic [3:0]     pal_hi;
  logic [PAW-1:0] ent_cnt;
  logic [IAW-1:0] pix_cnt;

  // Indices past the end of the palette are replaced by entry 0.
  assign in_range = int'(data_in) < PALETTE_DEPTH;

  // State register; reset wins over everything else.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state and status outputs; abort overrides any transition.
  always_comb begin
    state_n   = state;
    ready_out = 1'b0;
    busy_out  = 1'b0;
    done_out  = 1'b0;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        ready_out = !rst_in;
        accept    = valid_in && ready_out;
        if (accept) begin
          unique case (1'b1)
            (data_in == CMD_PAL): state_n = PAL_HI;
            (data_in == CMD_IMG): state_n = IMG;
            default:              state_n = IDLE;
          endcase
        end
      end
      PAL_HI: begin
        ready_out = !rst_in;
        busy_out  = 1'b1;
        accept    = valid_in && ready_out;
        if (accept) state_n = PAL_LO;
      end
      PAL_LO: begin
        ready_out = !rst_in;
        busy_out  = 1'b1;
        accept    = valid_in && ready_out;
        if (accept) begin
          state_n = (ent_cnt == LAST_ENT) ? IMG : PAL_HI;
        end
      end
      IMG: begin
        ready_out = !rst_in;
        busy_out  = 1'b1;
        accept    = valid_in && ready_out;
        if (accept && pix_cnt == LAST_PIX) state_n = DONE;
      end
      DONE: begin
        busy_out = 1'b1;
        done_out = 1'b1;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (abort_in) state_n = IDLE;
  end

  // Datapath: counters, palette assembly and 1-cycle write strobes.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      img_we_out   <= 1'b0;
      img_addr_out <= '0;
      img_data_out <= '0;
      pal_we_out   <= 1'b0;
      pal_addr_out <= '0;
      pal_data_out <= '0;
      err_out      <= 1'b0;
      pal_hi       <= '0;
      ent_cnt      <= '0;
      pix_cnt      <= '0;
    end else begin
      img_we_out <= 1'b0;
      pal_we_out <= 1'b0;
      err_out    <= 1'b0;
      if (abort_in) begin
        ent_cnt <= '0;
        pix_cnt <= '0;
      end else if (accept) begin
        unique case (state)
          IDLE: begin
            err_out <= (data_in != CMD_PAL) &&
                       (data_in != CMD_IMG);
            ent_cnt <= '0;
            pix_cnt <= '0;
          end
          PAL_HI: pal_hi <= data_in[3:0];
          PAL_LO: begin
            pal_we_out   <= 1'b1;
            pal_addr_out <= ent_cnt;
            pal_data_out <= {pal_hi, data_in};
            ent_cnt      <= (ent_cnt == LAST_ENT) ? '0
                            : ent_cnt + 1'b1;
          end
          IMG: begin
            img_we_out   <= 1'b1;
            img_addr_out <= pix_cnt;
            img_data_out <= in_range ? data_in : 8'd0;
            err_out      <= !in_range;
            pix_cnt      <= (pix_cnt == LAST_PIX) ? '0
                            : pix_cnt + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sprite_mem_loader.sv
// Scoreboard bench for sprite_mem_loader: a byte-level model
// predicts every write/err/done event, a monitor checks them.
module tb_sprite_mem_loader;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int PD = 4;
  localparam int N  = W * H;

  logic       clk = 1'b0;
  logic       rst_in;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic       abort_in;
  logic [2:0] img_addr_out;
  logic [7:0] img_data_out;
  logic       img_we_out;
  logic [1:0] pal_addr_out;
  logic [11:0] pal_data_out;
  logic       pal_we_out;
  logic       busy_out;
  logic       done_out;
  logic       err_out;

  int total = 0;
  int bad   = 0;

  sprite_mem_loader #(
    .WIDTH(W), .HEIGHT(H), .PALETTE_DEPTH(PD)
  ) dut (
    .pixel_clk_in(clk),
    .rst_in(rst_in),
    .data_in(data_in),
    .valid_in(valid_in),
    .ready_out(ready_out),
    .abort_in(abort_in),
    .img_addr_out(img_addr_out),
    .img_data_out(img_data_out),
    .img_we_out(img_we_out),
    .pal_addr_out(pal_addr_out),
    .pal_data_out(pal_data_out),
    .pal_we_out(pal_we_out),
    .busy_out(busy_out),
    .done_out(done_out),
    .err_out(err_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit pal;
    bit img;
    bit err;
    bit done;
    int addr;
    int data;
  } ev_t;

  ev_t q[$];

  // Reference model: position of each byte inside the load
  bit       in_load = 0;
  bit       is_pal  = 0;
  int       k       = 0;
  bit [3:0] hi      = 0;

  function automatic void push(bit p, bit i, bit e, bit d,
                               int a, int v);
    ev_t x;
    x.pal = p; x.img = i; x.err = e; x.done = d;
    x.addr = a; x.data = v;
    q.push_back(x);
  endfunction

  function automatic void model_accept(bit [7:0] b);
    int pix;
    if (!in_load) begin
      if (b == 8'hA5 || b == 8'h5A) begin
        in_load = 1; is_pal = (b == 8'hA5); k = 0;
      end else begin
        push(0, 0, 1, 0, 0, 0);
      end
    end else begin
      if (is_pal && k < 2 * PD) begin
        if (k % 2 == 0) hi = b[3:0];
        else push(1, 0, 0, 0, k / 2, {hi, b});
      end else begin
        pix = is_pal ? k - 2 * PD : k;
        push(0, 1, int'(b) >= PD, pix == N - 1, pix,
             (int'(b) < PD) ? int'(b) : 0);
        if (pix == N - 1) in_load = 0;
      end
      k++;
    end
  endfunction

  function automatic void model_abort();
    in_load = 0; k = 0;
  endfunction

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every output event must match the queue head
  always @(posedge clk) begin
    #1;
    if (!rst_in) begin
      if (img_we_out && pal_we_out) begin
        total++; bad++;
        $display("FAIL both_we: img and pal write together");
      end
      if (img_we_out || pal_we_out || err_out || done_out) begin
        ev_t e;
        int a;
        int v;
        a = img_we_out ? int'(img_addr_out)
          : pal_we_out ? int'(pal_addr_out) : 0;
        v = img_we_out ? int'(img_data_out)
          : pal_we_out ? int'(pal_data_out) : 0;
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_event: pal=%0b img=%0b err=%0b done=%0b addr=%0d data=%0h",
                   pal_we_out, img_we_out, err_out, done_out, a, v);
        end else begin
          e = q.pop_front();
          if (e.pal != pal_we_out || e.img != img_we_out ||
              e.err != err_out || e.done != done_out ||
              e.addr != a || e.data != v) begin
            bad++;
            $display("FAIL event: got pal=%0b img=%0b err=%0b done=%0b addr=%0d data=%0h expected pal=%0b img=%0b err=%0b done=%0b addr=%0d data=%0h",
                     pal_we_out, img_we_out, err_out, done_out, a, v,
                     e.pal, e.img, e.err, e.done, e.addr, e.data);
          end
        end
      end
    end
  end

  // Send one byte starting at a negedge; returns at a negedge
  task automatic send(logic [7:0] b, bit gaps);
    int t = 0;
    if (gaps && $urandom_range(0, 1) == 1) begin
      valid_in = 0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    data_in  = b;
    valid_in = 1;
    while (!ready_out && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!ready_out) begin
      total++; bad++;
      $display("FAIL ready_timeout: ready=%0b expected 1", ready_out);
      valid_in = 0;
      return;
    end
    @(posedge clk);
    model_accept(b);
    @(negedge clk);
    valid_in = 0;
  endtask

  task automatic do_abort();
    valid_in = 0;
    abort_in = 1;
    @(negedge clk);
    abort_in = 0;
    model_abort();
  endtask

  task automatic drain(int n);
    valid_in = 0;
    repeat (n) @(negedge clk);
  endtask

  logic [7:0] pal_bytes [8];
  logic [7:0] img_a [8];

  initial begin
    pal_bytes = '{8'h0F, 8'h00, 8'h00, 8'hF0,
                  8'h0F, 8'hFF, 8'h00, 8'h0F};
    img_a = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd3, 8'd2, 8'd1, 8'd0};
    rst_in = 1; valid_in = 0; abort_in = 0; data_in = 0;
    repeat (3) @(negedge clk);
    chk("ready_in_reset", ready_out, 0);
    rst_in = 0;
    @(negedge clk);
    chk("rst_ready", ready_out, 1);
    chk("rst_busy", busy_out, 0);
    chk("rst_done", done_out, 0);
    chk("rst_err", err_out, 0);
    chk("rst_img_we", img_we_out, 0);
    chk("rst_pal_we", pal_we_out, 0);
    chk("rst_img_addr", img_addr_out, 0);

    // 1: image-only load
    send(8'h5A, 0);
    chk("busy_after_cmd", busy_out, 1);
    foreach (img_a[i]) send(img_a[i], 0);
    chk("ready_in_done", ready_out, 0);
    drain(2);
    chk("busy_after_load", busy_out, 0);

    // 2: palette + image
    send(8'hA5, 0);
    foreach (pal_bytes[i]) send(pal_bytes[i], 0);
    foreach (img_a[i]) send(img_a[i], 0);
    drain(2);

    // 3: out-of-range index at pixel 3
    send(8'h5A, 0);
    for (int i = 0; i < N; i++) send((i == 3) ? 8'd7 : 8'(i % PD), 0);
    drain(2);

    // 4: bad command, then a normal load
    send(8'h33, 0);
    drain(1);
    chk("busy_after_bad", busy_out, 0);
    send(8'h5A, 0);
    foreach (img_a[i]) send(img_a[i], 0);
    drain(2);

    // 5: test 2 with random valid gaps
    send(8'hA5, 1);
    foreach (pal_bytes[i]) send(pal_bytes[i], 1);
    foreach (img_a[i]) send(img_a[i], 1);
    drain(2);

    // 6: abort after 3 image bytes, then full load
    send(8'h5A, 0);
    for (int i = 0; i < 3; i++) send(8'(i), 0);
    do_abort();
    chk("busy_after_abort", busy_out, 0);
    send(8'h5A, 0);
    foreach (img_a[i]) send(img_a[i], 0);
    drain(2);

    // byte presented with abort is dropped
    data_in = 8'h33; valid_in = 1; abort_in = 1;
    @(negedge clk);
    abort_in = 0; valid_in = 0;
    drain(2);

    // random loads with gaps, bad commands and aborts
    for (int l = 0; l < 25; l++) begin
      int r = $urandom_range(0, 9);
      int len;
      int ab;
      logic [7:0] cmd;
      cmd = (r < 4) ? 8'hA5 : (r < 8) ? 8'h5A
          : 8'($urandom_range(0, 255));
      send(cmd, 1);
      len = (cmd == 8'hA5) ? 2 * PD + N : (cmd == 8'h5A) ? N : 0;
      ab = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len) : -1;
      for (int i = 0; i < len; i++) begin
        if (i == ab) begin
          do_abort();
          break;
        end
        send(8'($urandom_range(0, 7)), 1);
      end
      drain(2);
    end

    drain(5);
    chk("queue_empty", q.size(), 0);
    chk("final_busy", busy_out, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
